imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Writer-side counterpart to the instruction memory read port.
- Receives a program image as a byte stream over a valid/ready handshake and assembles big-endian 32-bit words.
- Writes each word sequentially into instruction memory.
- Holds the pipeline in reset while loading, and releases it only after a successful load plus a settle delay.

Parameters:
DEPTH, 1024, instruction memory size in 32-bit words
ADDR_W, 10, width of the word address (clog2 of DEPTH)
POST_HOLD, 4, cycles cpu_reset stays high after the last word is written

Ports:
clk  input  1  system clock; all logic on posedge
reset  input  1  synchronous, active-high reset
start  input  1  one-cycle pulse; begins a load from IDLE, DONE or ERR
byte_valid  input  1  byte_data is valid this cycle
byte_data  input  8  stream byte
byte_ready  output  1  loader accepts a byte this cycle
imem_wr_en  output  1  one-cycle write strobe to instruction memory
imem_wr_addr  output  ADDR_W  word address of the write
imem_wr_data  output  32  word to write
cpu_reset  output  1  reset to the pipeline; high while not DONE
done  output  1  load complete; held until the next start or reset
error  output  1  header word count exceeds DEPTH; held until the next start or reset

Behaviour:
- Reset values (reset high at a posedge): state=IDLE, byte_ready=0, imem_wr_en=0, imem_wr_addr=0, imem_wr_data=0, cpu_reset=1, done=0, error=0. All internal counters clear.
- A byte is accepted only on a cycle with byte_valid && byte_ready.
- byte_ready is a registered output. It is 1 only in states LEN_HI, LEN_LO and DATA.
- Stream format:
  - 2-byte word count N, high byte first.
  - Then N words, 4 bytes each, MSB first. Word = {b0,b1,b2,b3}.
- States:
  - IDLE: byte_ready=0, cpu_reset=1. start -> LEN_HI.
  - LEN_HI: on accept, latch N[15:8] -> LEN_LO.
  - LEN_LO: on accept, latch N[7:0], then:
    - N==0 -> DRAIN (no writes).
    - N>DEPTH -> ERR.
    - otherwise -> DATA with word_idx=0, byte_idx=0.
  - DATA:
    - Each accepted byte shifts into the assembly register; byte_idx increments mod 4.
    - On the 4th byte, in the next cycle: imem_wr_en=1 for exactly one cycle, imem_wr_addr=word_idx, imem_wr_data=assembled word.
    - word_idx increments. byte_ready stays 1, so back-to-back bytes sustain 1 word per 4 cycles.
    - When the write of word N-1 is issued -> DRAIN; byte_ready drops in that same cycle.
  - DRAIN: byte_ready=0, cpu_reset=1. A counter runs POST_HOLD cycles -> DONE.
  - DONE: cpu_reset=0, done=1. start -> LEN_HI, which clears done and reasserts cpu_reset in the same cycle.
  - ERR: cpu_reset=1, error=1, byte_ready=0. start -> LEN_HI and clears error.
- start is ignored in LEN_HI, LEN_LO, DATA and DRAIN.
- Gaps in byte_valid stall assembly without loss. Partial-word state is retained indefinitely.
- imem_wr_addr and imem_wr_data hold their last values when imem_wr_en=0.
- Reset mid-load: return to IDLE, discard the partial word, cpu_reset=1. Words already written stay in memory. No write strobe is issued in the cycle reset is sampled.
- Simultaneous 4th-byte accept and reset: reset wins; no write.
- Boundaries:
  - N==DEPTH is legal; the last write goes to address DEPTH-1.
  - word_idx never wraps.
  - Bytes presented after the final word are not accepted (byte_ready=0).

Test Plan:
1. Normal load.
   - Stimulus: reset, start, stream 00 02 | 24 01 00 05 | 8C 02 00 04, byte_valid held high.
   - Required: writes addr0=0x24010005 and addr1=0x8C020004, each a one-cycle strobe. cpu_reset falls POST_HOLD=4 cycles after the 2nd write; done=1.
2. Throttled stream.
   - Stimulus: same image with byte_valid low on every other cycle.
   - Required: identical writes and data. byte_ready never drops before the last byte. Each word is written exactly once.
3. Zero-length load.
   - Stimulus: start, then 00 00.
   - Required: no imem_wr_en pulse; done=1 and cpu_reset=0 after 4 cycles.
4. Oversize header.
   - Stimulus: start, then 04 01 (N=1025).
   - Required: error=1, byte_ready=0, cpu_reset stays 1, no writes.
   - Follow-up: a new start followed by 00 01 DE AD BE EF writes addr0=0xDEADBEEF and clears error.
5. Reset mid-word.
   - Stimulus: after 1 full word plus 2 bytes of the second word, assert reset for 1 cycle.
   - Required: state IDLE, all outputs at reset values, no strobe for the partial word.
   - Follow-up: a fresh load restarts at addr0.
6. Full-depth load.
   - Stimulus: N=1024 with word k = k.
   - Required: 1024 strobes; the last is at addr 1023 with data 0x000003FF. An extra byte after the last word is not accepted.

Source files
------------

// File: rtl/imem_loader.sv
// Instruction memory loader: assembles big-endian words from a byte stream,
// writes them sequentially, and holds the pipeline in reset until the load settles.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | after reset; waits for start, pipeline held in reset
// LEN_HI | accepting high byte of the word count
// LEN_LO | accepting low byte of the word count; dispatch on N
// DATA   | accepting program bytes, one write per 4 bytes
// DRAIN  | last word written; settle counter runs before release
// DONE   | load complete, pipeline released; start reloads
// ERR    | header count exceeded DEPTH; start retries
module imem_loader #(
    parameter int DEPTH     = 1024,
    parameter int ADDR_W    = 10,
    parameter int POST_HOLD = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              imem_wr_en,
    output logic [ADDR_W-1:0] imem_wr_addr,
    output logic [31:0]       imem_wr_data,
    output logic              cpu_reset,
    output logic              done,
    output logic              error
);

    localparam int HOLD_W = (POST_HOLD > 1) ? $clog2(POST_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(POST_HOLD - 1);
    localparam logic [16:0] DEPTH_LIM = 17'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_DATA,
        S_DRAIN,
        S_DONE,
        S_ERR
    } state_t;

    state_t state, state_next;

    logic [7:0]        len_hi;
    logic [15:0]       n_words;
    logic [ADDR_W-1:0] word_idx;
    logic [1:0]        byte_idx;
    logic [23:0]       asm_word;
    logic [HOLD_W-1:0] hold_cnt;

    logic        accept;
    logic [15:0] len_full;
    logic        last_word;

    assign accept    = byte_valid && byte_ready;
    assign len_full  = {len_hi, byte_data};
    assign last_word = (16'(word_idx) == (n_words - 16'd1));

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) state_next = S_LEN_HI;
            end
            S_LEN_HI: begin
                if (accept) state_next = S_LEN_LO;
            end
            S_LEN_LO: begin
                if (accept) begin
                    if (len_full == 16'd0)
                        state_next = S_DRAIN;
                    else if ({1'b0, len_full} > DEPTH_LIM)
                        state_next = S_ERR;
                    else
                        state_next = S_DATA;
                end
            end
            S_DATA: begin
                if (accept && (byte_idx == 2'd3) && last_word) state_next = S_DRAIN;
            end
            S_DRAIN: begin
                if (hold_cnt == '0) state_next = S_DONE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            byte_ready   <= 1'b0;
            imem_wr_en   <= 1'b0;
            imem_wr_addr <= '0;
            imem_wr_data <= '0;
            cpu_reset    <= 1'b1;
            done         <= 1'b0;
            error        <= 1'b0;
            len_hi       <= '0;
            n_words      <= '0;
            word_idx     <= '0;
            byte_idx     <= '0;
            asm_word     <= '0;
            hold_cnt     <= '0;
        end else begin
            state      <= state_next;
            // Outputs follow the next state so they line up with the state register.
            byte_ready <= (state_next == S_LEN_HI) || (state_next == S_LEN_LO) ||
                          (state_next == S_DATA);
            cpu_reset  <= (state_next != S_DONE);
            done       <= (state_next == S_DONE);
            error      <= (state_next == S_ERR);
            imem_wr_en <= 1'b0;

            case (state)
                S_LEN_HI: begin
                    if (accept) len_hi <= byte_data;
                end
                S_LEN_LO: begin
                    if (accept) begin
                        n_words  <= len_full;
                        word_idx <= '0;
                        byte_idx <= '0;
                    end
                end
                S_DATA: begin
                    if (accept) begin
                        byte_idx <= byte_idx + 2'd1;
                        if (byte_idx == 2'd3) begin
                            imem_wr_en   <= 1'b1;
                            imem_wr_addr <= word_idx;
                            imem_wr_data <= {asm_word, byte_data};
                            // Stop at the final index so the address never wraps.
                            if (!last_word) word_idx <= word_idx + ADDR_W'(1);
                        end else begin
                            asm_word <= {asm_word[15:0], byte_data};
                        end
                    end
                end
                default: ;
            endcase

            if ((state_next == S_DRAIN) && (state != S_DRAIN))
                hold_cnt <= HOLD_LOAD;
            else if ((state == S_DRAIN) && (hold_cnt != '0))
                hold_cnt <= hold_cnt - HOLD_W'(1);
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboarded bench for imem_loader: directed byte streams push expected writes,
// a negedge monitor pops and compares every write strobe.
module tb_imem_loader;

    localparam int DEPTH     = 1024;
    localparam int ADDR_W    = 10;
    localparam int POST_HOLD = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              byte_ready;
    logic              imem_wr_en;
    logic [ADDR_W-1:0] imem_wr_addr;
    logic [31:0]       imem_wr_data;
    logic              cpu_reset;
    logic              done;
    logic              error;

    int vectors     = 0;
    int miscompares = 0;
    int wr_count    = 0;
    int w0;
    logic [ADDR_W+31:0] exp_q[$];
    logic [ADDR_W+31:0] mon_e;
    logic [ADDR_W-1:0]  last_addr;
    logic [31:0]        last_data;
    logic [7:0]         img[10] = '{8'h00, 8'h02, 8'h24, 8'h01, 8'h00,
                                    8'h05, 8'h8C, 8'h02, 8'h00, 8'h04};

    imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .POST_HOLD(POST_HOLD)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .byte_valid   (byte_valid),
        .byte_data    (byte_data),
        .byte_ready   (byte_ready),
        .imem_wr_en   (imem_wr_en),
        .imem_wr_addr (imem_wr_addr),
        .imem_wr_data (imem_wr_data),
        .cpu_reset    (cpu_reset),
        .done         (done),
        .error        (error)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (imem_wr_en === 1'b1) begin
            wr_count++;
            last_addr = imem_wr_addr;
            last_data = imem_wr_data;
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_write: got addr %0d data 0x%08h, want no write",
                         imem_wr_addr, imem_wr_data);
            end else begin
                mon_e = exp_q.pop_front();
                check("wr_addr", 32'(imem_wr_addr), 32'(mon_e[ADDR_W+31:32]));
                check("wr_data", imem_wr_data, mon_e[31:0]);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n = 0;
        byte_valid = 1'b0;
        repeat (gap) tick();
        byte_valid = 1'b1;
        byte_data  = b;
        while (byte_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        if (byte_ready !== 1'b1) begin
            vectors++;
            miscompares++;
            $display("FAIL send_timeout: byte_ready low for 20 cycles, want 1");
        end
        tick();
        byte_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int addr, input int gap);
        exp_q.push_back({ADDR_W'(addr), w});
        send_byte(w[31:24], gap);
        send_byte(w[23:16], gap);
        send_byte(w[15:8], gap);
        send_byte(w[7:0], gap);
    endtask

    // Counts cycles until the pipeline is released; byte_ready must stay low throughout.
    task automatic wait_done(input string name, input int exp_cycles);
        int n = 0;
        bit rdy = 1'b0;
        while (cpu_reset !== 1'b0 && n < 50) begin
            tick();
            n++;
            if (byte_ready !== 1'b0) rdy = 1'b1;
        end
        check({name, "_hold_cycles"}, n, exp_cycles);
        check({name, "_done"}, 32'(done), 32'd1);
        check({name, "_ready_in_drain"}, 32'(rdy), 32'd0);
    endtask

    task automatic check_reset_state(input string name);
        check({name, "_byte_ready"}, 32'(byte_ready), 32'd0);
        check({name, "_wr_en"}, 32'(imem_wr_en), 32'd0);
        check({name, "_wr_addr"}, 32'(imem_wr_addr), 32'd0);
        check({name, "_wr_data"}, imem_wr_data, 32'd0);
        check({name, "_cpu_reset"}, 32'(cpu_reset), 32'd1);
        check({name, "_done"}, 32'(done), 32'd0);
        check({name, "_error"}, 32'(error), 32'd0);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        repeat (2) tick();
        reset = 1'b0;
        check_reset_state("rst");

        // Normal load
        w0 = wr_count;
        pulse_start();
        check("t1_ready_after_start", 32'(byte_ready), 32'd1);
        check("t1_cpu_reset_loading", 32'(cpu_reset), 32'd1);
        send_byte(8'h00, 0);
        send_byte(8'h02, 0);
        send_word(32'h24010005, 0, 0);
        send_word(32'h8C020004, 1, 0);
        check("t1_last_strobe", 32'(imem_wr_en), 32'd1);
        check("t1_ready_drop", 32'(byte_ready), 32'd0);
        wait_done("t1", POST_HOLD);
        check("t1_write_count", wr_count - w0, 32'd2);

        // Throttled stream
        w0 = wr_count;
        pulse_start();
        check("t2_done_cleared", 32'(done), 32'd0);
        check("t2_cpu_reset_reasserted", 32'(cpu_reset), 32'd1);
        exp_q.push_back({ADDR_W'(0), 32'h24010005});
        exp_q.push_back({ADDR_W'(1), 32'h8C020004});
        for (int i = 0; i < 10; i++) begin
            send_byte(img[i], 1);
            if (i < 9) check("t2_ready_held", 32'(byte_ready), 32'd1);
        end
        wait_done("t2", POST_HOLD);
        check("t2_write_count", wr_count - w0, 32'd2);

        // Zero-length load
        w0 = wr_count;
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        check("t3_no_strobe", 32'(imem_wr_en), 32'd0);
        wait_done("t3", POST_HOLD);
        check("t3_write_count", wr_count - w0, 32'd0);

        // Oversize header, then recovery
        w0 = wr_count;
        pulse_start();
        send_byte(8'h04, 0);
        send_byte(8'h01, 0);
        check("t4_error", 32'(error), 32'd1);
        check("t4_ready", 32'(byte_ready), 32'd0);
        check("t4_cpu_reset", 32'(cpu_reset), 32'd1);
        repeat (3) tick();
        check("t4_error_held", 32'(error), 32'd1);
        check("t4_cpu_reset_held", 32'(cpu_reset), 32'd1);
        check("t4_no_writes", wr_count - w0, 32'd0);
        pulse_start();
        check("t4_error_cleared", 32'(error), 32'd0);
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        send_word(32'hDEADBEEF, 0, 0);
        wait_done("t4", POST_HOLD);
        check("t4_write_count", wr_count - w0, 32'd1);

        // Reset mid-word, then fresh load
        w0 = wr_count;
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h02, 0);
        send_word(32'h12345678, 0, 0);
        send_byte(8'hAB, 0);
        send_byte(8'hCD, 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_reset_state("t5");
        repeat (3) tick();
        check("t5_partial_not_written", wr_count - w0, 32'd1);
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        send_word(32'h0BADF00D, 0, 0);
        wait_done("t5", POST_HOLD);

        // Full-depth load with a trailing byte that must be refused
        w0 = wr_count;
        pulse_start();
        send_byte(8'h04, 0);
        send_byte(8'h00, 0);
        for (int k = 0; k < DEPTH; k++) send_word(32'(k), k, 0);
        check("t6_last_strobe", 32'(imem_wr_en), 32'd1);
        byte_valid = 1'b1;
        byte_data  = 8'hAA;
        check("t6_extra_refused", 32'(byte_ready), 32'd0);
        wait_done("t6", POST_HOLD);
        byte_valid = 1'b0;
        check("t6_write_count", wr_count - w0, 32'(DEPTH));
        check("t6_last_addr", 32'(last_addr), 32'd1023);
        check("t6_last_data", last_data, 32'h000003FF);
        check("scoreboard_drained", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
